// File: rtl/vga_pkg.sv
// Shared timing constants, phase encoding and total-length helpers for the VGA timing path.
// Defaults describe 640x480@60 with a 2:1 system-to-pixel clock ratio.
package vga_pkg;

  localparam int unsigned DEF_HRES    = 640;
  localparam int unsigned DEF_HFP     = 16;
  localparam int unsigned DEF_HSW     = 96;
  localparam int unsigned DEF_HBP     = 48;
  localparam int unsigned DEF_VRES    = 480;
  localparam int unsigned DEF_VFP     = 10;
  localparam int unsigned DEF_VSW     = 2;
  localparam int unsigned DEF_VBP     = 33;
  localparam int unsigned DEF_CLK_DIV = 2;

  localparam int unsigned POS_W       = 10;
  localparam int unsigned MAX_TOTAL   = 1 << POS_W;
  localparam int unsigned DIV_W       = 4;
  localparam int unsigned MAX_CLK_DIV = 16;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} vga_phase_t;

  function automatic int unsigned htotal(input int unsigned hres, input int unsigned hfp,
                                         input int unsigned hsw, input int unsigned hbp);
    return hres + hfp + hsw + hbp;
  endfunction

  function automatic int unsigned vtotal(input int unsigned vres, input int unsigned vfp,
                                         input int unsigned vsw, input int unsigned vbp);
    return vres + vfp + vsw + vbp;
  endfunction

endpackage

// File: rtl/vga_sync_axis.sv
// One timing axis: position counter plus an active/front/sync/back phase FSM.
// pos is registered; phase is the phase pos will be in after the current edge.
module vga_sync_axis
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE_LEN = DEF_HRES,
  parameter int unsigned FRONT_LEN  = DEF_HFP,
  parameter int unsigned SYNC_LEN   = DEF_HSW,
  parameter int unsigned BACK_LEN   = DEF_HBP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [POS_W-1:0] pos,
  output vga_phase_t       phase,
  output logic             wrap
);

  if (ACTIVE_LEN == 0 || FRONT_LEN == 0 || SYNC_LEN == 0 || BACK_LEN == 0) begin : g_len_chk
    $error("vga_sync_axis: every phase length must be at least 1");
  end

  vga_phase_t       phase_q, phase_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] last;

  always_comb begin
    last = '0;
    unique case (phase_q)
      ACTIVE: last = POS_W'(ACTIVE_LEN - 1);
      FRONT:  last = POS_W'(FRONT_LEN - 1);
      SYNC:   last = POS_W'(SYNC_LEN - 1);
      BACK:   last = POS_W'(BACK_LEN - 1);
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    if (en) begin
      pos_d = pos_q + 1'b1;
      if (cnt_q == last) begin
        cnt_d = '0;
        unique case (phase_q)
          ACTIVE: phase_d = FRONT;
          FRONT:  phase_d = SYNC;
          SYNC:   phase_d = BACK;
          BACK: begin
            phase_d = ACTIVE;
            pos_d   = '0;
            wrap    = 1'b1;
          end
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= ACTIVE;
      pos_q   <= '0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pos   = pos_q;
  // Look-ahead lets the parent register decoded syncs on the same edge as pos.
  assign phase = phase_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: clock divider, horizontal/vertical axes and registered
// sync, blanking and line/frame markers that all describe the same pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned HRES    = DEF_HRES,
  parameter int unsigned VRES    = DEF_VRES,
  parameter int unsigned HFP     = DEF_HFP,
  parameter int unsigned HSW     = DEF_HSW,
  parameter int unsigned HBP     = DEF_HBP,
  parameter int unsigned VFP     = DEF_VFP,
  parameter int unsigned VSW     = DEF_VSW,
  parameter int unsigned VBP     = DEF_VBP,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pix_en,
  output logic [POS_W-1:0] x,
  output logic [POS_W-1:0] y,
  output logic             hsync,
  output logic             vsync,
  output logic             blank_n,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned HTOTAL = htotal(HRES, HFP, HSW, HBP);
  localparam int unsigned VTOTAL = vtotal(VRES, VFP, VSW, VBP);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (HTOTAL > MAX_TOTAL || VTOTAL > MAX_TOTAL) begin : g_total_chk
    $error("vga_timing_gen: HTOTAL=%0d / VTOTAL=%0d exceed %0d", HTOTAL, VTOTAL, MAX_TOTAL);
  end

  if (CLK_DIV == 0 || CLK_DIV > MAX_CLK_DIV) begin : g_div_chk
    $error("vga_timing_gen: CLK_DIV=%0d outside 1..%0d", CLK_DIV, MAX_CLK_DIV);
  end

  logic [DIV_W-1:0] div_cnt_q;
  logic             pix_en_q;
  logic             div_last;

  assign div_last = (div_cnt_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      pix_en_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_last ? '0 : div_cnt_q + 1'b1;
      pix_en_q  <= div_last;
    end
  end

  logic [POS_W-1:0] h_pos, v_pos;
  vga_phase_t       h_phase, v_phase;
  logic             h_wrap, v_wrap;

  vga_sync_axis #(
    .ACTIVE_LEN (HRES),
    .FRONT_LEN  (HFP),
    .SYNC_LEN   (HSW),
    .BACK_LEN   (HBP)
  ) u_h_axis (
    .clk   (clk),
    .rst   (rst),
    .en    (pix_en_q),
    .pos   (h_pos),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  // Vertical axis steps once per line, on the strobe that wraps x.
  vga_sync_axis #(
    .ACTIVE_LEN (VRES),
    .FRONT_LEN  (VFP),
    .SYNC_LEN   (VSW),
    .BACK_LEN   (VBP)
  ) u_v_axis (
    .clk   (clk),
    .rst   (rst),
    .en    (h_wrap),
    .pos   (v_pos),
    .phase (v_phase),
    .wrap  (v_wrap)
  );

  logic hsync_q, vsync_q, blank_n_q, line_start_q, frame_start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= (h_phase != SYNC);
      vsync_q       <= (v_phase != SYNC);
      blank_n_q     <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap && v_wrap;
    end
  end

  assign pix_en      = pix_en_q;
  assign x           = h_pos;
  assign y           = v_pos;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_n_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds checked every clock against a closed-form
// timing model through a scoreboard queue, plus directed line/frame measurements.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, rst_a, rst_b;

  logic       pe_d, hs_d, vs_d, bn_d, ls_d, fs_d;
  logic [9:0] x_d, y_d;
  logic       pe_a, hs_a, vs_a, bn_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       pe_b, hs_b, vs_b, bn_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;

  // Default 640x480 build, CLK_DIV=2.
  vga_timing_gen u_dut_d (
    .clk (clk), .rst (rst_d), .pix_en (pe_d), .x (x_d), .y (y_d), .hsync (hs_d),
    .vsync (vs_d), .blank_n (bn_d), .line_start (ls_d), .frame_start (fs_d)
  );

  // Tiny build: CLK_DIV=1, 8x4, porches of 1 -> 11-clock line, 77-clock frame.
  vga_timing_gen #(
    .HRES (8), .VRES (4), .HFP (1), .HSW (1), .HBP (1), .VFP (1), .VSW (1), .VBP (1),
    .CLK_DIV (1)
  ) u_dut_a (
    .clk (clk), .rst (rst_a), .pix_en (pe_a), .x (x_a), .y (y_a), .hsync (hs_a),
    .vsync (vs_a), .blank_n (bn_a), .line_start (ls_a), .frame_start (fs_a)
  );

  // Odd divider with unequal porches: 11x8 totals, CLK_DIV=3.
  vga_timing_gen #(
    .HRES (5), .VRES (3), .HFP (2), .HSW (3), .HBP (1), .VFP (1), .VSW (2), .VBP (2),
    .CLK_DIV (3)
  ) u_dut_b (
    .clk (clk), .rst (rst_b), .pix_en (pe_b), .x (x_b), .y (y_b), .hsync (hs_b),
    .vsync (vs_b), .blank_n (bn_b), .line_start (ls_b), .frame_start (fs_b)
  );

  typedef struct {
    int          id;
    int          t;
    logic [25:0] exp;
  } sb_t;

  sb_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int t_d = 0, t_a = 0, t_b = 0;

  bit tally_on = 1'b0;
  int hs_low_d, ls_cnt_d, fall_x_d;
  bit bn_prev_d;
  int fs_cnt_a, ls_frame_a, last_fs_a, period_a;

  // Expected outputs after the t-th clock edge since reset release (t=0: in reset).
  function automatic logic [25:0] model(int t, int d, int hr, int hf, int hs, int hb,
                                        int vr, int vf, int vs, int vb);
    int   ht, vt, n, px, py;
    logic pe, upd, in_hs, in_vs, blank;
    if (t == 0) return {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ht    = hr + hf + hs + hb;
    vt    = vr + vf + vs + vb;
    n     = (t - 1) / d;
    px    = n % ht;
    py    = (n / ht) % vt;
    pe    = (t % d) == 0;
    upd   = (t >= d + 1) && (((t - 1) % d) == 0);
    in_hs = (px >= hr + hf) && (px < hr + hf + hs);
    in_vs = (py >= vr + vf) && (py < vr + vf + vs);
    blank = (px < hr) && (py < vr);
    return {pe, 10'(px), 10'(py), !in_hs, !in_vs, blank, upd && px == 0,
            upd && px == 0 && py == 0};
  endfunction

  function automatic logic [25:0] obs_of(int id);
    case (id)
      0:       return {pe_d, x_d, y_d, hs_d, vs_d, bn_d, ls_d, fs_d};
      1:       return {pe_a, x_a, y_a, hs_a, vs_a, bn_a, ls_a, fs_a};
      default: return {pe_b, x_b, y_b, hs_b, vs_b, bn_b, ls_b, fs_b};
    endcase
  endfunction

  task automatic check_vec(string tag, logic [25:0] obs, logic [25:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_expected();
    sb_q.push_back('{id: 0, t: t_d, exp: model(t_d, 2, 640, 16, 96, 48, 480, 10, 2, 33)});
    sb_q.push_back('{id: 1, t: t_a, exp: model(t_a, 1, 8, 1, 1, 1, 4, 1, 1, 1)});
    sb_q.push_back('{id: 2, t: t_b, exp: model(t_b, 3, 5, 2, 3, 1, 3, 1, 2, 2)});
  endtask

  task automatic step();
    sb_t e;
    @(negedge clk);
    if (!rst_d) t_d++;
    if (!rst_a) t_a++;
    if (!rst_b) t_b++;
    push_expected();
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_vec($sformatf("dut%0d_t%0d", e.id, e.t), obs_of(e.id), e.exp);
    end
    if (tally_on) begin
      if (pe_d && !hs_d) hs_low_d++;
      if (ls_d) ls_cnt_d++;
      if (bn_prev_d && !bn_d && fall_x_d < 0) fall_x_d = int'(x_d);
      bn_prev_d = bn_d;
      if (fs_a) begin
        if (last_fs_a >= 0) period_a = t_a - last_fs_a;
        last_fs_a = t_a;
        fs_cnt_a++;
      end
      if (ls_a && fs_cnt_a == 1) ls_frame_a++;
    end
  endtask

  task automatic check_reset_now(string tag);
    push_expected();
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      check_vec($sformatf("%s%0d", tag, e.id), obs_of(e.id), e.exp);
    end
  endtask

  initial begin
    rst_d = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    rst_d = 1'b1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    check_reset_now("reset_state");
    repeat (3) step();

    rst_d = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2) step();
    check_int("pix_en_clk2", int'(pe_d), 1);
    step();
    check_int("x_clk3", int'(x_d), 1);
    check_int("y_clk3", int'(y_d), 0);

    // Run to x=300 on the default build, then reset between edges.
    repeat (598) step();
    check_int("x_before_rst", int'(x_d), 300);
    #2;
    rst_d = 1'b1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    t_d = 0;
    t_a = 0;
    t_b = 0;
    #1;
    check_reset_now("async_rst");
    repeat (2) step();

    rst_d     = 1'b0;
    rst_a     = 1'b0;
    rst_b     = 1'b0;
    hs_low_d  = 0;
    ls_cnt_d  = 0;
    fall_x_d  = -1;
    bn_prev_d = 1'b1;
    fs_cnt_a  = 0;
    ls_frame_a = 0;
    last_fs_a = -1;
    period_a  = -1;
    tally_on  = 1'b1;
    repeat (1601) step();

    check_int("hsync_low_strobes", hs_low_d, 96);
    check_int("blank_fall_x", fall_x_d, 640);
    check_int("line_start_count", ls_cnt_d, 1);
    check_int("line_start_800th", int'(ls_d), 1);
    check_int("y_after_line", int'(y_d), 1);
    check_int("tiny_frame_period", period_a, 77);
    check_int("tiny_lines_per_frame", ls_frame_a, 7);
    check_int("tiny_frame_count", fs_cnt_a, 20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
